// File: rtl/seq_ripple_subtractor_pkg.sv
// rtl/seq_ripple_subtractor_pkg.sv - shared state encoding and sizing helpers for the sequential subtractor
package seq_ripple_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 8;
    localparam int NCHUNK    = DEF_WIDTH / DEF_CHUNK;

    // A single-chunk configuration still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int CNT_W = cnt_width(NCHUNK);

endpackage

// File: rtl/seq_ripple_subtractor_ripple_sub_chunk.sv
// rtl/seq_ripple_subtractor_ripple_sub_chunk.sv - CHUNK-bit combinational ripple-borrow subtractor slice
module ripple_sub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             borrow_in,
    output logic [CHUNK-1:0] d,
    output logic             borrow_out
);

    logic [CHUNK:0] chain;

    assign chain[0] = borrow_in;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign d[i]         = x[i] ^ y[i] ^ chain[i];
        assign chain[i + 1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & chain[i]);
    end

    assign borrow_out = chain[CHUNK];

endmodule

// File: rtl/seq_ripple_subtractor.sv
// rtl/seq_ripple_subtractor.sv - multi-cycle a - b - borrow_i, CHUNK bits per clock with ready/valid on both sides
module seq_ripple_subtractor
    import seq_ripple_subtractor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_o,
    output logic             zero,
    output logic             overflow
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = cnt_width(NCH);

    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
        $error("CHUNK must evenly divide WIDTH");
    end

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             borrow_reg;

    logic [CHUNK-1:0] x;
    logic [CHUNK-1:0] y;
    logic [CHUNK-1:0] d;
    logic             chunk_borrow;
    logic [WIDTH-1:0] diff_next;
    logic             last;
    int               idx;

    // diff_next is the result with the current chunk merged in, so the
    // flags on the final chunk see the complete difference.
    always_comb begin
        idx       = int'(cnt) * CHUNK;
        x         = a_reg[idx +: CHUNK];
        y         = b_reg[idx +: CHUNK];
        diff_next = diff_reg;
        diff_next[idx +: CHUNK] = d;
    end

    assign last = (cnt == CW'(NCH - 1));

    ripple_sub_chunk #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .x         (x),
        .y         (y),
        .borrow_in (borrow_reg),
        .d         (d),
        .borrow_out(chunk_borrow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            borrow_reg <= 1'b0;
            diff_reg   <= '0;
            borrow_o   <= 1'b0;
            zero       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg      <= a;
                        b_reg      <= b;
                        borrow_reg <= borrow_i;
                        cnt        <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    diff_reg   <= diff_next;
                    borrow_reg <= chunk_borrow;
                    if (last) begin
                        cnt      <= '0;
                        borrow_o <= chunk_borrow;
                        zero     <= (diff_next == '0);
                        overflow <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) &
                                    (diff_next[WIDTH-1] ^ a_reg[WIDTH-1]);
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign diff      = diff_reg;

endmodule

// File: tb/tb_seq_ripple_subtractor.sv
// tb/tb_seq_ripple_subtractor.sv - randomized self-checking bench for seq_ripple_subtractor at CHUNK = 8, 4, 1, 32
module tb_seq_ripple_subtractor;
    import seq_ripple_subtractor_pkg::*;

    localparam int W  = 32;
    localparam int NI = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NI-1:0] in_valid, in_ready, borrow_i, out_valid, out_ready;
    logic [NI-1:0] borrow_o, zero, overflow;
    logic [W-1:0]  a [NI];
    logic [W-1:0]  b [NI];
    logic [W-1:0]  diff [NI];

    int n_cmp = 0;
    int n_err = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int CH = (g == 0) ? 8 : (g == 1) ? 4 : (g == 2) ? 1 : 32;
        seq_ripple_subtractor #(
            .WIDTH(W),
            .CHUNK(CH)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .a        (a[g]),
            .b        (b[g]),
            .borrow_i (borrow_i[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .diff     (diff[g]),
            .borrow_o (borrow_o[g]),
            .zero     (zero[g]),
            .overflow (overflow[g])
        );
    end

    function automatic int nchunk_of(input int i);
        case (i)
            0:       return NCHUNK;
            1:       return W / 4;
            2:       return W / 1;
            default: return W / 32;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on wide values.
    task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                         output logic [W-1:0] d, output logic bo, output logic z, output logic ov);
        longint unsigned ua, ub;
        longint          sd;
        logic signed [W-1:0] t;
        ua = longint'(av);
        ub = longint'(bv);
        bo = (ua < ub + longint'(bi));
        d  = W'(ua - ub - longint'(bi));
        z  = (d == '0);
        sd = longint'($signed(av)) - longint'($signed(bv)) - longint'(bi);
        t  = W'(sd);
        ov = (longint'(t) != sd);
    endtask

    task automatic run_op(input int i, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic bi, input int stall);
        logic [W-1:0] ed;
        logic eb, ez, eo;
        int lat;
        model(av, bv, bi, ed, eb, ez, eo);
        @(negedge clk);
        check($sformatf("in_ready_idle[%0d]", i), 64'(in_ready[i]), 64'd1);
        a[i] = av;
        b[i] = bv;
        borrow_i[i] = bi;
        in_valid[i] = 1'b1;
        @(negedge clk);
        in_valid[i] = 1'b0;
        a[i] = $urandom;
        b[i] = $urandom;
        borrow_i[i] = 1'($urandom);
        lat = 0;
        while (!out_valid[i] && lat < 200) begin
            out_ready[i] = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        out_ready[i] = 1'b0;
        check($sformatf("latency[%0d]", i), 64'(lat), 64'(nchunk_of(i)));
        for (int s = 0; s < stall; s++) begin
            check($sformatf("in_ready_done[%0d]", i), 64'(in_ready[i]), 64'd0);
            in_valid[i] = 1'($urandom);
            a[i] = $urandom;
            b[i] = $urandom;
            @(negedge clk);
        end
        in_valid[i] = 1'b0;
        check($sformatf("out_valid[%0d]", i), 64'(out_valid[i]), 64'd1);
        check($sformatf("diff[%0d]", i), 64'(diff[i]), 64'(ed));
        check($sformatf("borrow_o[%0d]", i), 64'(borrow_o[i]), 64'(eb));
        check($sformatf("zero[%0d]", i), 64'(zero[i]), 64'(ez));
        check($sformatf("overflow[%0d]", i), 64'(overflow[i]), 64'(eo));
        out_ready[i] = 1'b1;
        @(negedge clk);
        out_ready[i] = 1'b0;
        check($sformatf("out_valid_drop[%0d]", i), 64'(out_valid[i]), 64'd0);
        check($sformatf("in_ready_back[%0d]", i), 64'(in_ready[i]), 64'd1);
    endtask

    initial begin
        int nops [NI];
        logic [W-1:0] av, bv;
        nops = '{2000, 1200, 400, 2000};
        rst = 1'b1;
        in_valid = '0;
        borrow_i = '0;
        out_ready = '0;
        for (int i = 0; i < NI; i++) begin
            a[i] = '0;
            b[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_in_ready", 64'(in_ready[0]), 64'd1);
        check("rst_out_valid", 64'(out_valid[0]), 64'd0);
        check("rst_diff", 64'(diff[0]), 64'd0);
        check("rst_borrow_o", 64'(borrow_o[0]), 64'd0);
        check("rst_zero", 64'(zero[0]), 64'd0);
        check("rst_overflow", 64'(overflow[0]), 64'd0);

        run_op(0, 32'd5, 32'd3, 1'b0, 0);
        check("five_minus_three", 64'(diff[0]), 64'd2);
        run_op(0, 32'd0, 32'd1, 1'b0, 1);
        run_op(0, 32'h8000_0000, 32'd1, 1'b0, 0);
        run_op(0, 32'h1234_5678, 32'h1234_5678, 1'b1, 2);
        run_op(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 10);

        // Abort an operation two cycles into BUSY.
        @(negedge clk);
        a[0] = 32'hFFFF_FFFF;
        b[0] = 32'h0000_0001;
        borrow_i[0] = 1'b1;
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", 64'(in_ready[0]), 64'd1);
        check("abort_out_valid", 64'(out_valid[0]), 64'd0);
        check("abort_diff", 64'(diff[0]), 64'd0);
        check("abort_flags", 64'({borrow_o[0], zero[0], overflow[0]}), 64'd0);
        run_op(0, 32'd10, 32'd4, 1'b0, 0);
        check("after_abort", 64'(diff[0]), 64'd6);

        for (int i = 0; i < NI; i++) begin
            for (int n = 0; n < nops[i]; n++) begin
                av = $urandom;
                bv = ($urandom_range(0, 7) == 0) ? av : $urandom;
                run_op(i, av, bv, 1'($urandom), $urandom_range(0, 3));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
